// File: rtl/fu_ctrl_pkg.sv
// Shared definitions for the function-unit sequencer: FSM state codes, CTRL
// sub-opcodes, function-select constants and status bit positions.
package fu_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_FETCH   = 3'd0;
    localparam state_t ST_DECODE  = 3'd1;
    localparam state_t ST_EXEC    = 3'd2;
    localparam state_t ST_WB      = 3'd3;
    localparam state_t ST_HALT    = 3'd4;
    localparam state_t ST_ILLEGAL = 3'd5;

    localparam logic [2:0] SUB_LDI  = 3'b000;
    localparam logic [2:0] SUB_BRZ  = 3'b001;
    localparam logic [2:0] SUB_BRN  = 3'b010;
    localparam logic [2:0] SUB_JMP  = 3'b011;
    localparam logic [2:0] SUB_HALT = 3'b100;

    localparam logic [3:0] FS_PASSB = 4'b1100;
    localparam logic [3:0] FS_NOP   = 4'b1111;

    // Positions inside the latched {V,C,N,Z} status word
    localparam int STAT_V = 3;
    localparam int STAT_C = 2;
    localparam int STAT_N = 1;
    localparam int STAT_Z = 0;

    function automatic logic sub_is_illegal(input logic [2:0] sub);
        return (sub > SUB_HALT);
    endfunction

endpackage

// File: rtl/fu_ctrl_decode.sv
// Combinational instruction decoder: splits an instruction word into the
// control fields the sequencer registers in DECODE.
module fu_ctrl_decode
    import fu_ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PC_W   = 8
) (
    input  logic [DATA_W-1:0] i_ir,
    output logic              o_is_alu,
    output logic [2:0]        o_sub,
    output logic [3:0]        o_fs,
    output logic [2:0]        o_dr,
    output logic [2:0]        o_sa,
    output logic [2:0]        o_sb,
    output logic [DATA_W-1:0] o_imm_sext,
    output logic [PC_W-1:0]   o_imm_pc,
    output logic              o_illegal
);

    logic [8:0] w_imm9;

    assign w_imm9     = i_ir[8:0];
    assign o_imm_sext = {{(DATA_W-9){w_imm9[8]}}, w_imm9};

    // PC arithmetic is modulo 2^PC_W, so a narrow PC only needs the low bits
    generate
        if (PC_W <= 9) begin : g_pc_narrow
            assign o_imm_pc = w_imm9[PC_W-1:0];
        end else begin : g_pc_wide
            assign o_imm_pc = {{(PC_W-9){w_imm9[8]}}, w_imm9};
        end
    endgenerate

    always_comb begin
        o_is_alu  = ~i_ir[15];
        o_sub     = 3'b000;
        o_fs      = FS_NOP;
        o_dr      = 3'b000;
        o_sa      = 3'b000;
        o_sb      = 3'b000;
        o_illegal = 1'b0;
        if (!i_ir[15]) begin
            o_fs = i_ir[14:11];
            o_dr = i_ir[10:8];
            o_sa = i_ir[7:5];
            o_sb = i_ir[4:2];
        end else begin
            o_sub     = i_ir[14:12];
            o_dr      = i_ir[11:9];
            o_fs      = (i_ir[14:12] == SUB_LDI) ? FS_PASSB : FS_NOP;
            o_illegal = sub_is_illegal(i_ir[14:12]);
        end
    end

endmodule

// File: rtl/fu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer driving the 16-bit function unit
// and register file, with latched V/C/N/Z flags for conditional branches.
module fu_sequencer
    import fu_ctrl_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              DATA_W   = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [3:0]        fs,
    output logic [2:0]        sa,
    output logic [2:0]        sb,
    output logic [2:0]        dr,
    output logic              rf_we,
    output logic              mb_sel,
    output logic [DATA_W-1:0] const_out,
    input  logic              v_in,
    input  logic              c_in,
    input  logic              n_in,
    input  logic              z_in,
    output logic [3:0]        status,
    output logic [PC_W-1:0]   pc_out,
    output logic              halted,
    output logic              illegal
);

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [DATA_W-1:0]   r_ir;
    logic [3:0]          r_status;
    logic                r_is_alu;
    logic [2:0]          r_sub;
    logic [3:0]          r_fs;
    logic [2:0]          r_dr;
    logic [2:0]          r_sa;
    logic [2:0]          r_sb;
    logic [DATA_W-1:0]   r_const;
    logic [PC_W-1:0]     r_imm_pc;

    logic                w_is_alu;
    logic [2:0]          w_sub;
    logic [3:0]          w_fs;
    logic [2:0]          w_dr;
    logic [2:0]          w_sa;
    logic [2:0]          w_sb;
    logic [DATA_W-1:0]   w_imm_sext;
    logic [PC_W-1:0]     w_imm_pc;
    logic                w_illegal;
    logic                w_taken;
    logic                w_active;

    fu_ctrl_decode #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W)
    ) u_decode (
        .i_ir       (r_ir),
        .o_is_alu   (w_is_alu),
        .o_sub      (w_sub),
        .o_fs       (w_fs),
        .o_dr       (w_dr),
        .o_sa       (w_sa),
        .o_sb       (w_sb),
        .o_imm_sext (w_imm_sext),
        .o_imm_pc   (w_imm_pc),
        .o_illegal  (w_illegal)
    );

    // Branch conditions look only at the flags latched by an earlier WB
    assign w_taken = (r_sub == SUB_JMP)
                   || ((r_sub == SUB_BRZ) && r_status[STAT_Z])
                   || ((r_sub == SUB_BRN) && r_status[STAT_N]);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= ST_FETCH;
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_status <= '0;
            r_is_alu <= 1'b0;
            r_sub    <= 3'b000;
            r_fs     <= FS_NOP;
            r_dr     <= 3'b000;
            r_sa     <= 3'b000;
            r_sb     <= 3'b000;
            r_const  <= '0;
            r_imm_pc <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_ir    <= imem_rdata;
                        r_pc    <= r_pc + PC_W'(1);
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_is_alu <= w_is_alu;
                    r_sub    <= w_sub;
                    r_fs     <= w_fs;
                    r_dr     <= w_dr;
                    r_sa     <= w_sa;
                    r_sb     <= w_sb;
                    r_const  <= w_imm_sext;
                    r_imm_pc <= w_imm_pc;
                    if (w_illegal)
                        r_state <= ST_ILLEGAL;
                    else if (!w_is_alu && (w_sub == SUB_HALT))
                        r_state <= ST_HALT;
                    else
                        r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (r_is_alu || (r_sub == SUB_LDI)) begin
                        r_state <= ST_WB;
                    end else begin
                        if (w_taken)
                            r_pc <= r_pc + r_imm_pc;
                        r_state <= ST_FETCH;
                    end
                end
                ST_WB: begin
                    if (r_is_alu && (r_fs != FS_NOP))
                        r_status <= {v_in, c_in, n_in, z_in};
                    r_state <= ST_FETCH;
                end
                default: r_state <= r_state;
            endcase
        end
    end

    // ALU and LDI are the only instructions that drive the function unit
    assign w_active  = ((r_state == ST_EXEC) || (r_state == ST_WB))
                     && (r_is_alu || (r_sub == SUB_LDI));

    assign imem_req  = (r_state == ST_FETCH) && !RESET;
    assign imem_addr = r_pc;
    assign pc_out    = r_pc;
    assign fs        = w_active ? r_fs : FS_NOP;
    assign mb_sel    = w_active && !r_is_alu;
    assign rf_we     = (r_state == ST_WB) && w_active && (r_fs != FS_NOP) && !RESET;
    assign sa        = r_sa;
    assign sb        = r_sb;
    assign dr        = r_dr;
    assign const_out = r_const;
    assign status    = r_status;
    assign halted    = (r_state == ST_HALT);
    assign illegal   = (r_state == ST_ILLEGAL);

endmodule

// File: tb/tb_fu_sequencer.sv
// Directed bench for fu_sequencer: fetch handshake, ALU/LDI write-back, flag
// latching, branches, PC wrap, illegal/halt traps and reset corner cases.
module tb_fu_sequencer;

    logic        CLK;
    logic        RESET;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [3:0]  fs;
    logic [2:0]  sa;
    logic [2:0]  sb;
    logic [2:0]  dr;
    logic        rf_we;
    logic        mb_sel;
    logic [15:0] const_out;
    logic        v_in;
    logic        c_in;
    logic        n_in;
    logic        z_in;
    logic [3:0]  status;
    logic [7:0]  pc_out;
    logic        halted;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    fu_sequencer #(
        .PC_W     (8),
        .RESET_PC (8'h00),
        .DATA_W   (16)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .fs         (fs),
        .sa         (sa),
        .sb         (sb),
        .dr         (dr),
        .rf_we      (rf_we),
        .mb_sel     (mb_sel),
        .const_out  (const_out),
        .v_in       (v_in),
        .c_in       (c_in),
        .n_in       (n_in),
        .z_in       (z_in),
        .status     (status),
        .pc_out     (pc_out),
        .halted     (halted),
        .illegal    (illegal)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic flags(input logic [3:0] f);
        {v_in, c_in, n_in, z_in} = f;
    endtask

    // Serve one fetch: wait (bounded) for req, hold off 'waits' cycles, then ack
    task automatic fetch(input logic [7:0] addr, input logic [15:0] word,
                         input int waits, input string tag);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 16) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_req"}, imem_req, 1);
        chk({tag, "_addr"}, imem_addr, addr);
        for (int i = 0; i < waits; i++) begin
            @(negedge CLK);
            chk({tag, "_req_held"}, imem_req, 1);
        end
        imem_rdata = word;
        imem_ack   = 1'b1;
        @(negedge CLK);
        imem_ack   = 1'b0;
        imem_rdata = 16'hDEAD;
    endtask

    initial begin
        RESET      = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        flags(4'b0000);
        repeat (2) tick();

        chk("rst_req", imem_req, 0);
        chk("rst_fs", fs, 4'hF);
        chk("rst_sa", sa, 0);
        chk("rst_sb", sb, 0);
        chk("rst_dr", dr, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_mb_sel", mb_sel, 0);
        chk("rst_const", const_out, 0);
        chk("rst_status", status, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        RESET = 1'b0;
        #1 chk("req_after_rst", imem_req, 1);

        // ALU fs=0010 dr=2 sa=1 sb=5 after three wait cycles
        fetch(8'h00, 16'h1234, 3, "t1");
        chk("t1_dec_req", imem_req, 0);
        chk("t1_dec_pc", pc_out, 8'h01);
        chk("t1_dec_fs", fs, 4'hF);
        tick();
        chk("t1_ex_fs", fs, 4'h2);
        chk("t1_ex_sa", sa, 1);
        chk("t1_ex_sb", sb, 5);
        chk("t1_ex_mb", mb_sel, 0);
        chk("t1_ex_we", rf_we, 0);
        tick();
        chk("t1_wb_we", rf_we, 1);
        chk("t1_wb_dr", dr, 2);
        chk("t1_wb_fs", fs, 4'h2);
        flags(4'b1010);
        tick();
        flags(4'b0000);
        chk("t1_status", status, 4'b1010);
        chk("t1_fetch_we", rf_we, 0);

        // LDI dr=3 imm=-1, with a stray ack during DECODE/EXEC
        fetch(8'h01, 16'h87FF, 0, "t2");
        imem_ack   = 1'b1;
        imem_rdata = 16'h1234;
        tick();
        chk("t2_ex_const", const_out, 16'hFFFF);
        chk("t2_ex_mb", mb_sel, 1);
        chk("t2_ex_fs", fs, 4'hC);
        chk("t2_ex_we", rf_we, 0);
        tick();
        imem_ack = 1'b0;
        chk("t2_wb_we", rf_we, 1);
        chk("t2_wb_dr", dr, 3);
        chk("t2_wb_mb", mb_sel, 1);
        chk("t2_wb_fs", fs, 4'hC);
        chk("t2_stray_pc", pc_out, 8'h02);
        flags(4'b0101);
        tick();
        flags(4'b0000);
        chk("t2_status", status, 4'b1010);
        chk("t2_fetch_mb", mb_sel, 0);

        // Set Z, NOP leaves it, BRZ -2 from PC=4 taken
        fetch(8'h02, 16'h0000, 0, "t3a");
        repeat (2) tick();
        flags(4'b0001);
        tick();
        flags(4'b0000);
        chk("t3_status_z", status, 4'b0001);
        fetch(8'h03, 16'h7800, 0, "t3nop");
        tick();
        chk("t3_nop_fs", fs, 4'hF);
        tick();
        chk("t3_nop_we", rf_we, 0);
        flags(4'b1111);
        tick();
        flags(4'b0000);
        chk("t3_nop_status", status, 4'b0001);
        fetch(8'h04, 16'h91FE, 0, "t3brz");
        chk("t3_brz_dec_pc", pc_out, 8'h05);
        tick();
        chk("t3_brz_ex_we", rf_we, 0);
        chk("t3_brz_ex_fs", fs, 4'hF);
        tick();
        chk("t3_brz_taken_pc", pc_out, 8'h03);
        chk("t3_brz_addr", imem_addr, 8'h03);

        // Clear Z, BRZ not taken
        fetch(8'h03, 16'h0000, 0, "t3b");
        repeat (2) tick();
        flags(4'b0000);
        tick();
        chk("t3_status_clr", status, 4'b0000);
        fetch(8'h04, 16'h91FE, 0, "t3brz2");
        repeat (2) tick();
        chk("t3_brz_nt_pc", pc_out, 8'h05);

        // JMP to 0xFF, wrap on fetch, JMP -256, self-loops
        fetch(8'h05, 16'hB0F9, 0, "t5a");
        repeat (2) tick();
        chk("t5_pc_ff", pc_out, 8'hFF);
        fetch(8'hFF, 16'hB010, 0, "t5b");
        chk("t5_wrap_pc", pc_out, 8'h00);
        repeat (2) tick();
        chk("t5_jmp10_pc", pc_out, 8'h10);
        fetch(8'h10, 16'hB100, 0, "t5c");
        chk("t5_dec_pc", pc_out, 8'h11);
        repeat (2) tick();
        chk("t5_jmp256_pc", pc_out, 8'h11);
        fetch(8'h11, 16'hB1FF, 0, "t5d");
        repeat (2) tick();
        chk("t5_self_pc", pc_out, 8'h11);
        fetch(8'h11, 16'h0000, 0, "t5e");
        repeat (2) tick();
        flags(4'b0010);
        tick();
        flags(4'b0000);
        chk("t5_status_n", status, 4'b0010);
        fetch(8'h12, 16'hA1FF, 0, "t5f");
        repeat (2) tick();
        chk("t5_brn_self_pc", pc_out, 8'h12);

        // Illegal sub-opcode traps until reset
        fetch(8'h12, 16'hD000, 0, "t4");
        chk("t4_dec_illegal", illegal, 0);
        tick();
        chk("t4_illegal", illegal, 1);
        chk("t4_req", imem_req, 0);
        repeat (3) tick();
        chk("t4_illegal_sticky", illegal, 1);
        chk("t4_req_quiet", imem_req, 0);
        chk("t4_halted", halted, 0);
        chk("t4_pc", pc_out, 8'h13);
        RESET = 1'b1;
        tick();
        chk("t4_rst_illegal", illegal, 0);
        chk("t4_rst_pc", pc_out, 8'h00);
        chk("t4_rst_status", status, 0);

        // Ack coinciding with reset is ignored
        imem_ack   = 1'b1;
        imem_rdata = 16'h1234;
        #1 chk("t6_req_in_rst", imem_req, 0);
        tick();
        imem_ack = 1'b0;
        chk("t6_pc", pc_out, 8'h00);
        chk("t6_req_next", imem_req, 0);
        RESET = 1'b0;
        #1 chk("t6_req_back", imem_req, 1);
        fetch(8'h00, 16'h7800, 0, "t6nop");
        chk("t6_dec_pc", pc_out, 8'h01);
        tick();
        chk("t6_ex_fs", fs, 4'hF);
        tick();
        chk("t6_wb_we", rf_we, 0);
        tick();

        // HALT
        fetch(8'h01, 16'hC000, 0, "th");
        chk("th_dec_halted", halted, 0);
        tick();
        chk("th_halted", halted, 1);
        repeat (3) tick();
        chk("th_sticky", halted, 1);
        chk("th_req", imem_req, 0);
        chk("th_pc", pc_out, 8'h02);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;

        // Reset arriving in WB suppresses rf_we
        fetch(8'h00, 16'h1234, 0, "tw");
        repeat (2) tick();
        chk("tw_wb_we", rf_we, 1);
        RESET = 1'b1;
        #1 chk("tw_rst_we", rf_we, 0);
        tick();
        RESET = 1'b0;
        chk("tw_fs", fs, 4'hF);
        chk("tw_pc", pc_out, 8'h00);
        chk("tw_halted", halted, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
